// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and the recognizer benches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width needed to hold a length value 0..max_len inclusive.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_MAX_LEN = 16;
  localparam int LEN_W       = calc_len_w(DEF_MAX_LEN);

  // Default recognizer stimulus pattern, sent MSB first.
  localparam int                        SEQ_11011_LEN = 5;
  localparam logic [SEQ_11011_LEN-1:0]  SEQ_11011     = 5'b11011;

endpackage

// File: rtl/seq_tick_gen.sv
// Bit-period divider: pulses tick in the last of every DIV enabled cycles.
// Latency: tick is combinational from the count register; first tick DIV-1 cycles after enable rises.
// Backpressure: none; clear or enable=0 restarts the period from zero.
//
// Ports:
//   sysclk, rst : clock and asynchronous active-high reset
//   clear       : restart the period (count back to 0)
//   enable      : count while high, hold at 0 while low
//   tick        : high in the final cycle of each DIV-cycle period
module seq_tick_gen #(
  parameter int DIV = 4
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV=1 LAST is 0, so every enabled cycle ticks.
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Serial bit-sequence generator: shifts a 1..MAX_LEN bit pattern out MSB first, DIV cycles per bit.
// Latency: first bit appears the cycle after an accepted start; done strobes the cycle after the last bit.
// Backpressure: none; start is ignored while busy, stop ends repetition after the current frame.
//
// Ports:
//   sysclk, rst        : clock and asynchronous active-high reset
//   start              : frame request, honoured only when idle with 1<=len<=MAX_LEN
//   pattern, len       : frame contents, captured into shadow registers at start
//   repeat_en, stop    : back-to-back repetition control, evaluated at each frame end
//   data_out, bit_valid: serial data and first-cycle-of-bit strobe
//   busy, done         : frame in progress / one-cycle frame-end strobe
//   frame_cnt          : completed frames since reset, wrapping
module seq_gen
  import seq_pkg::*;
#(
  parameter  int DIV     = 4,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = 8,
  localparam int LW      = calc_len_w(MAX_LEN)
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic               repeat_en,
  input  logic               stop,
  output logic               data_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int               IW    = $clog2(MAX_LEN);
  localparam logic [LW-1:0]    ONE_L = LW'(1);
  localparam logic [LW-1:0]    MAX_L = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic               stop_q, stop_d;
  logic               dout_q, dout_d;
  logic               bv_q, bv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               len_ok;
  logic               start_ok;
  logic               tick;
  logic [IW-1:0]      start_ix, next_ix, first_ix;

  assign len_ok   = (len != '0) && (len <= MAX_L);
  // Bit positions: first bit of a new frame, next bit of the running frame,
  // and first bit of a repeated frame (taken from the shadow copy).
  assign start_ix = IW'(len - ONE_L);
  assign next_ix  = IW'(idx_q - ONE_L);
  assign first_ix = IW'(len_q - ONE_L);

  seq_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .sysclk(sysclk),
    .rst   (rst),
    .clear (start_ok),
    .enable(state_q == SHIFT),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    dout_d   = dout_q;
    bv_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    start_ok = 1'b0;

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start && len_ok) begin
          start_ok = 1'b1;
          state_d  = SHIFT;
          pat_d    = pattern;
          len_d    = len;
          idx_d    = len - ONE_L;
          dout_d   = pattern[start_ix];
          bv_d     = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        // A stop seen in the frame-end cycle itself also counts as pending.
        stop_d = stop_q | stop;
        if (tick) begin
          if (idx_q != '0) begin
            idx_d  = idx_q - ONE_L;
            dout_d = pat_q[next_ix];
            bv_d   = 1'b1;
          end else begin
            done_d = 1'b1;
            cnt_d  = cnt_q + ONE_C;
            if (repeat_en && !(stop_q || stop)) begin
              // Back-to-back restart: first bit overlaps the done strobe.
              idx_d  = len_q - ONE_L;
              dout_d = pat_q[first_ix];
              bv_d   = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              dout_d  = 1'b0;
              stop_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      dout_q  <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = dout_q;
  assign bit_valid = bv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule
